// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: opcodes, FSM encoding and
// the small decode helpers used when capturing a response.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  // One requester's operation as presented on the request channel.
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
  } alu_req_t;

  // The ALU only drives a meaningful carry for add/sub; otherwise it is stale.
  function automatic logic carry_valid(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

  function automatic logic is_div_zero(input logic [3:0] opcode, input logic [7:0] operand2);
    return (opcode == OP_DIV) && (operand2 == 8'h00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the pointer is owned and
// advanced by the parent on a completed handshake.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  input  logic en,
  output logic gnt_id,
  output logic gnt_valid
);

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    gnt_valid = en && (req0 || req1);
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = ptr;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external combinational ALU between two requesters. Accepts one
// operation at a time, holds its operands on the ALU for EXEC_CYCLES cycles,
// then captures result/flags into a tagged response channel.
module alu_req_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_operand1,
  input  logic [7:0]       req0_operand2,
  input  logic [3:0]       req0_opcode,
  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_operand1,
  input  logic [7:0]       req1_operand2,
  input  logic [3:0]       req1_opcode,
  // ALU side
  output logic [7:0]       alu_operand1,
  output logic [7:0]       alu_operand2,
  output logic [3:0]       alu_opcode,
  input  logic [15:0]      alu_result,
  input  logic             alu_flag_c,
  input  logic             alu_flag_z,
  // Response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_result,
  output logic             rsp_flag_c,
  output logic             rsp_flag_z,
  output logic             rsp_err,
  // Status
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned WaitW = ($clog2(EXEC_CYCLES + 1) > 1) ? $clog2(EXEC_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(EXEC_CYCLES - 1);

  seq_state_t       state_q;
  logic             ptr_q;
  logic             id_q;
  logic [WaitW-1:0] wait_q;

  logic             gnt_id;
  logic             gnt_valid;
  alu_req_t         sel_req;

  logic             div_zero;
  logic [15:0]      cap_result;
  logic             cap_flag_c;
  logic             cap_flag_z;

  rr_arbiter2 u_arb (
    .req0      (req0_valid),
    .req1      (req1_valid),
    .ptr       (ptr_q),
    .en        (state_q == IDLE),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid && gnt_id;
  assign busy       = (state_q != IDLE);

  // Select the granted requester's operation.
  always_comb begin
    sel_req = '{opcode: req0_opcode, operand1: req0_operand1, operand2: req0_operand2};
    if (gnt_id) begin
      sel_req = '{opcode: req1_opcode, operand1: req1_operand1, operand2: req1_operand2};
    end
  end

  // Response capture values, masking the ALU's stale carry and divide-by-zero garbage.
  always_comb begin
    div_zero   = is_div_zero(alu_opcode, alu_operand2);
    cap_result = alu_result;
    cap_flag_z = alu_flag_z;
    cap_flag_c = carry_valid(alu_opcode) ? alu_flag_c : 1'b0;
    if (div_zero) begin
      cap_result = 16'h0000;
      cap_flag_z = 1'b0;
      cap_flag_c = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      wait_q       <= '0;
      alu_operand1 <= 8'h00;
      alu_operand2 <= 8'h00;
      alu_opcode   <= 4'h0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 16'h0000;
      rsp_flag_c   <= 1'b0;
      rsp_flag_z   <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            alu_operand1 <= sel_req.operand1;
            alu_operand2 <= sel_req.operand2;
            alu_opcode   <= sel_req.opcode;
            id_q         <= gnt_id;
            wait_q       <= WaitLoad;
            ptr_q        <= ~gnt_id;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WaitW'(1);
          end else begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= cap_result;
            rsp_flag_c <= cap_flag_c;
            rsp_flag_z <= cap_flag_z;
            rsp_err    <= div_zero;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Protocol invariants.
  assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid && !rsp_ready |=> rsp_valid &&
      $stable({rsp_id, rsp_result, rsp_flag_c, rsp_flag_z, rsp_err}));

  assert property (@(posedge clk) disable iff (!rst_n) !(req0_ready && req1_ready));

  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (!req0_ready && !req1_ready));

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer: directed operations push hand-computed
// responses into a queue, a monitor pops and compares on each response handshake.
module tb_alu_req_sequencer;
  import alu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  rsp_t exp_q[$];
  rsp_t exp3_q[$];

  // DUT with EXEC_CYCLES=1
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [7:0]  alu_operand1, alu_operand2;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_flag_c, alu_flag_z;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_flag_c, rsp_flag_z, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [15:0] op_count;

  // DUT with EXEC_CYCLES=3
  logic        x_rst_n;
  logic        x_req0_valid, x_req0_ready, x_req1_ready;
  logic [7:0]  x_req0_operand1, x_req0_operand2;
  logic [3:0]  x_req0_opcode;
  logic [7:0]  x_alu_operand1, x_alu_operand2;
  logic [3:0]  x_alu_opcode;
  logic [15:0] x_alu_result;
  logic        x_alu_flag_c, x_alu_flag_z;
  logic        x_rsp_valid, x_rsp_id, x_rsp_flag_c, x_rsp_flag_z, x_rsp_err, x_busy;
  logic [15:0] x_rsp_result;
  logic [15:0] x_op_count;

  alu_req_sequencer #(.EXEC_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand1(req0_operand1), .req0_operand2(req0_operand2), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand1(req1_operand1), .req1_operand2(req1_operand2), .req1_opcode(req1_opcode),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flag_c(alu_flag_c), .alu_flag_z(alu_flag_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flag_c(rsp_flag_c), .rsp_flag_z(rsp_flag_z), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  alu_req_sequencer #(.EXEC_CYCLES(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(x_rst_n),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready),
    .req0_operand1(x_req0_operand1), .req0_operand2(x_req0_operand2),
    .req0_opcode(x_req0_opcode),
    .req1_valid(1'b0), .req1_ready(x_req1_ready),
    .req1_operand1(8'h00), .req1_operand2(8'h00), .req1_opcode(4'h0),
    .alu_operand1(x_alu_operand1), .alu_operand2(x_alu_operand2), .alu_opcode(x_alu_opcode),
    .alu_result(x_alu_result), .alu_flag_c(x_alu_flag_c), .alu_flag_z(x_alu_flag_z),
    .rsp_valid(x_rsp_valid), .rsp_ready(1'b1), .rsp_id(x_rsp_id), .rsp_result(x_rsp_result),
    .rsp_flag_c(x_rsp_flag_c), .rsp_flag_z(x_rsp_flag_z), .rsp_err(x_rsp_err),
    .busy(x_busy), .op_count(x_op_count)
  );

  // Stand-in ALU: carry is left at 1 (stale) for non add/sub ops, and divide by
  // zero returns deliberate garbage so the sequencer's masking is visible.
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] r;
    logic [8:0]  t;
    logic        c;
    r = 16'h0000;
    c = 1'b1;
    t = 9'h000;
    case (op)
      OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = {7'b0, t}; c = t[8]; end
      OP_SUB: begin t = {1'b0, a} - {1'b0, b}; r = {8'h00, t[7:0]}; c = t[8]; end
      OP_MUL: r = {8'h00, a} * {8'h00, b};
      OP_DIV: r = (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
      OP_AND: r = {8'h00, a & b};
      OP_OR:  r = {8'h00, a | b};
      OP_XOR: r = {8'h00, a ^ b};
      OP_NOR: r = {8'h00, ~(a | b)};
      default: r = 16'h0000;
    endcase
    if (op == OP_DIV && b == 8'h00) return {1'b1, 1'b1, r};
    return {c, (r == 16'h0000), r};
  endfunction

  always_comb {alu_flag_c, alu_flag_z, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2);
  always_comb {x_alu_flag_c, x_alu_flag_z, x_alu_result} =
    alu_fn(x_alu_opcode, x_alu_operand1, x_alu_operand2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic id, input logic [15:0] res, input logic c,
                               input logic z, input logic err);
    rsp_t e;
    e.id = id; e.res = res; e.c = c; e.z = z; e.err = err;
    exp_q.push_back(e);
  endfunction

  // Response monitor for the EXEC_CYCLES=1 instance.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_result", rsp_result, e.res);
          check("rsp_flag_c", rsp_flag_c, e.c);
          check("rsp_flag_z", rsp_flag_z, e.z);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  // Response monitor for the EXEC_CYCLES=3 instance (rsp_ready tied high).
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (x_rsp_valid) begin
        if (exp3_q.size() == 0) begin
          check("x_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp3_q.pop_front();
          check("x_rsp_id", x_rsp_id, e.id);
          check("x_rsp_result", x_rsp_result, e.res);
          check("x_rsp_flag_c", x_rsp_flag_c, e.c);
          check("x_rsp_flag_z", x_rsp_flag_z, e.z);
          check("x_rsp_err", x_rsp_err, e.err);
        end
      end
    end
  end

  // Present one operation and hold it until accepted; returns 1 ns after the accept edge.
  task automatic drive(input bit r, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    bit done;
    done = 1'b0;
    @(negedge clk);
    if (r) begin
      req1_valid = 1'b1; req1_opcode = op; req1_operand1 = a; req1_operand2 = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_operand1 = a; req0_operand2 = b;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (r ? req1_ready : req0_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (r) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    if (!done) check(r ? "req1_accept_timeout" : "req0_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; x_rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_operand1 = '0; req0_operand2 = '0; req0_opcode = '0;
    req1_valid = 1'b0; req1_operand1 = '0; req1_operand2 = '0; req1_opcode = '0;
    x_req0_valid = 1'b0; x_req0_operand1 = '0; x_req0_operand2 = '0; x_req0_opcode = '0;

    // Reset values
    #2;
    check("rst_alu_operand1", alu_operand1, 32'h0);
    check("rst_alu_operand2", alu_operand2, 32'h0);
    check("rst_alu_opcode", alu_opcode, 32'h0);
    check("rst_rsp_valid", rsp_valid, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_op_count", op_count, 32'h0);
    check("rst_req0_ready", req0_ready, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; x_rst_n = 1'b1;

    // Single ADD with carry out, response one cycle after accept
    push(1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    drive(1'b0, OP_ADD, 8'hFF, 8'h01);
    check("t1_busy", busy, 32'h1);
    check("t1_rsp_valid_early", rsp_valid, 32'h0);
    check("t1_alu_operand1", alu_operand1, 32'hFF);
    check("t1_alu_operand2", alu_operand2, 32'h01);
    check("t1_req0_ready_exec", req0_ready, 32'h0);
    @(posedge clk); #1;
    check("t1_rsp_valid", rsp_valid, 32'h1);
    @(posedge clk); #1;
    check("t1_op_count", op_count, 32'd1);
    check("t1_busy_after", busy, 32'h0);
    check("t1_rsp_result_retained", rsp_result, 32'h0100);
    check("t1_alu_operand1_retained", alu_operand1, 32'hFF);

    // AND after a carry-producing ADD: stale carry must be masked
    push(1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    push(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, OP_ADD, 8'h80, 8'h80);
    drive(1'b0, OP_AND, 8'hF0, 8'h0F);
    wait_drain();
    check("t2_op_count", op_count, 32'd3);

    // Divide by zero then a normal divide
    push(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    push(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_DIV, 8'd10, 8'd0);
    drive(1'b1, OP_DIV, 8'd10, 8'd3);
    wait_drain();
    check("t3_op_count", op_count, 32'd5);

    // Both requesters busy: pointer is 0 here, so grants go 0,1,0,1,...
    push(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    push(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    push(1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    push(1'b1, 16'h00FE, 1'b1, 1'b0, 1'b0);
    push(1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0);
    push(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    push(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    push(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    fork
      begin
        drive(1'b0, OP_ADD, 8'h01, 8'h02);
        drive(1'b0, OP_SUB, 8'h05, 8'h03);
        drive(1'b0, OP_OR, 8'hA0, 8'h05);
        drive(1'b0, OP_XOR, 8'hFF, 8'hFF);
      end
      begin
        drive(1'b1, OP_MUL, 8'h10, 8'h10);
        drive(1'b1, OP_SUB, 8'h03, 8'h05);
        drive(1'b1, OP_AND, 8'h3C, 8'hF0);
        drive(1'b1, OP_NOR, 8'h00, 8'hFF);
      end
    join
    wait_drain();
    check("t4_op_count", op_count, 32'd13);

    // Response backpressure with requester 1 waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    push(1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    push(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    fork
      drive(1'b0, OP_ADD, 8'h10, 8'h20);
      drive(1'b1, OP_SUB, 8'h50, 8'h10);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk); #1;
          seen = rsp_valid;
        end
        check("t5_rsp_valid_wait", seen, 32'h1);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("t5_hold_valid", rsp_valid, 32'h1);
          check("t5_hold_result", rsp_result, 32'h0030);
          check("t5_hold_id", rsp_id, 32'h0);
          check("t5_hold_req0_ready", req0_ready, 32'h0);
          check("t5_hold_req1_ready", req1_ready, 32'h0);
          check("t5_hold_busy", busy, 32'h1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_idle_busy", busy, 32'h0);
        check("t5_idle_req1_ready", req1_ready, 32'h1);
        @(posedge clk); #1;
        check("t5_next_accept_busy", busy, 32'h1);
      end
    join
    wait_drain();
    check("t5_op_count", op_count, 32'd15);

    // EXEC_CYCLES=3: reset during EXEC drops the operation
    @(negedge clk);
    x_req0_valid = 1'b1; x_req0_opcode = OP_MUL; x_req0_operand1 = 8'd200;
    x_req0_operand2 = 8'd2;
    #1;
    check("x_ready_first", x_req0_ready, 32'h1);
    @(posedge clk); #1;
    x_req0_valid = 1'b0;
    @(negedge clk);
    check("x_busy_exec", x_busy, 32'h1);
    check("x_alu_operand1", x_alu_operand1, 32'd200);
    #1;
    x_rst_n = 1'b0;
    #1;
    check("x_rst_busy", x_busy, 32'h0);
    check("x_rst_alu_operand1", x_alu_operand1, 32'h0);
    check("x_rst_alu_operand2", x_alu_operand2, 32'h0);
    check("x_rst_alu_opcode", x_alu_opcode, 32'h0);
    check("x_rst_rsp_valid", x_rsp_valid, 32'h0);
    check("x_rst_rsp_result", x_rsp_result, 32'h0);
    check("x_rst_op_count", x_op_count, 32'h0);
    @(negedge clk);
    x_rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (x_rsp_valid) seen = 1'b1;
    end
    check("x_no_rsp_after_reset", seen, 32'h0);

    // Fresh MUL: response three cycles after accept
    begin
      rsp_t e;
      e.id = 1'b0; e.res = 16'd400; e.c = 1'b0; e.z = 1'b0; e.err = 1'b0;
      exp3_q.push_back(e);
    end
    @(negedge clk);
    x_req0_valid = 1'b1; x_req0_opcode = OP_MUL; x_req0_operand1 = 8'd200;
    x_req0_operand2 = 8'd2;
    #1;
    check("x_ready_fresh", x_req0_ready, 32'h1);
    @(posedge clk); #1;
    x_req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("x_rsp_valid_timing", x_rsp_valid, (k == 3) ? 32'h1 : 32'h0);
    end
    check("x_rsp_result_400", x_rsp_result, 32'd400);
    repeat (3) @(negedge clk);
    check("x_op_count", x_op_count, 32'd1);

    check("sb_empty", exp_q.size(), 32'd0);
    check("sb3_empty", exp3_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
- Shares the single combinational ALU between two requesters using valid/ready handshakes.
- Arbitrates round-robin, registers the accepted operands and drives them into the ALU.
- Waits a programmable number of cycles, then captures the result and flags and returns them on a response channel tagged with the requester ID.
- Sits between the requester front-ends and the ALU instance; the ALU is instantiated alongside it, not inside it.

Parameters:
- EXEC_CYCLES, 1, cycles operands are held on the ALU before the result is sampled (≥1; covers multicycle multiply/divide paths).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Req0Valid  in  1  requester 0 has an operation.
- Req0Ready  out  1  requester 0 operation accepted this cycle.
- Req0Operand1  in  8  requester 0 operand 1.
- Req0Operand2  in  8  requester 0 operand 2.
- Req0Opcode  in  4  requester 0 opcode.
- Req1Valid, Req1Ready, Req1Operand1, Req1Operand2, Req1Opcode: same as requester 0, for requester 1.
- AluOperand1  out  8  registered operand 1 to the ALU.
- AluOperand2  out  8  registered operand 2 to the ALU.
- AluOpcode  out  4  registered opcode to the ALU.
- AluResult  in  16  ALU result.
- AluFlagC  in  1  ALU carry flag.
- AluFlagZ  in  1  ALU zero flag.
- RspValid  out  1  response available.
- RspReady  in  1  consumer takes the response.
- RspId  out  1  requester that issued the operation.
- RspResult  out  16  captured result.
- RspFlagC  out  1  captured carry.
- RspFlagZ  out  1  captured zero.
- RspErr  out  1  divide-by-zero.
- Busy  out  1  state ≠ IDLE.
- OpCount  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync-released by the system):
  - state=IDLE; round-robin pointer=0.
  - All Alu*, Rsp*, Busy and OpCount are 0; Req*Ready are 0.
  - Reset mid-operation drops the in-flight operation with no response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - ReqNReady = (state==IDLE) && grant==N, combinational from the Valid inputs and the pointer.
  - Grant: only one valid → that requester. Both valid → requester indicated by the pointer.
  - On handshake: register operands, opcode and ID into the Alu* and internal registers; load the wait counter with EXEC_CYCLES-1; pointer ← ~grantedId; go to EXEC.
  - No valid requests: stay in IDLE, pointer unchanged.
- EXEC:
  - Alu* outputs are stable.
  - Counter ≠0: decrement.
  - Counter ==0: capture the response registers, assert RspValid, go to RESP.
  - Accepted at edge t0 → RspValid high after edge t0+EXEC_CYCLES.
- Capture rules:
  - RspResult=AluResult.
  - RspFlagZ=AluFlagZ.
  - RspFlagC=AluFlagC only for opcodes ADD(0000) and SUB(0001); 0 otherwise, because the ALU holds a stale carry on other opcodes.
  - Divide-by-zero (opcode 0011, Operand2==0): RspErr=1, RspResult=16'h0000, RspFlagC=0, RspFlagZ=0. RspErr=0 for all other operations.
- RESP:
  - All Rsp* held stable while RspValid && !RspReady.
  - On RspValid && RspReady: RspValid←0, OpCount←OpCount+1 (wraps), go to IDLE.
  - Rsp data registers retain their last value after the handshake.
- Throughput: with RspReady tied high, one operation every EXEC_CYCLES+2 cycles.
- Req*Ready is 0 in EXEC and RESP; a requester must hold its Valid and data stable until Ready.
- Counter width is $clog2(EXEC_CYCLES+1), minimum 1.
- Alu* registers keep the last operation after completion; no clear to 0 in IDLE.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=4'b0000, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ=4'b1111.
  - Sequencer state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module rr_arbiter2:
  - Inputs: two request lines, pointer, enable.
  - Output: grant id and grant-valid (combinational).
  - Pointer flip on handshake is owned by the parent.

Test Plan:
- Req0 only, ADD 8'hFF+8'h01, EXEC_CYCLES=1, RspReady=1 → RspValid one cycle after accept; RspId=0, RspResult=16'h0100, RspFlagC=1, RspFlagZ=0, OpCount=1.
- Both valid every cycle, 4 ops each → grants strictly alternate 0,1,0,1…; RspId sequence matches; OpCount=8.
- AND 8'hF0 & 8'h0F following an ADD with carry=1 → RspResult=0, RspFlagZ=1, RspFlagC=0.
- DIV 8'd10 / 8'd0 → RspErr=1, RspResult=0, RspFlagZ=0. Then DIV 8'd10 / 8'd3 → RspResult=3, RspErr=0.
- RspReady held low 5 cycles in RESP → Rsp* stable, Req*Ready=0, Busy=1; releasing Ready → IDLE, next accept one cycle later.
- EXEC_CYCLES=3, MUL 8'd200×8'd2 with Rst_n pulsed low during EXEC → all outputs 0 immediately, no RspValid; a fresh MUL after reset returns 16'd400 three cycles after accept.
